// File: rtl/ir_nec_transmitter.sv
// ---------------------------------------------------------------------------
// ir_nec_transmitter
//   NEC-format IR frame generator. On an accepted start it sends:
//   lead mark, lead space, 32 data bits ({~key, key, CUSTOM_CODE}, bit 0
//   first, each bit = mark + length-coded space), stop mark, then an
//   idle-high guard gap. A one-cycle done pulse ends the frame.
//
//   Build option: define IR_CARRIER_EN to modulate marks with a square
//   carrier (toggle every CARRIER_HALF cycles). Without it IRDA_TXD is the
//   baseband envelope (mark = 0), which ir_sniffer decodes directly.
//
// Ports
//   clk       in   clock (50 MHz)
//   rst       in   asynchronous reset, active high
//   start     in   frame request, sampled only in IDLE
//   key_code  in   [7:0] key byte, captured with the accepted start
//   busy      out  high from accepted start through end of guard gap
//   done      out  one-cycle pulse when the guard gap completes
//   IRDA_TXD  out  registered IR output; idle/space = 1, mark = 0
// ---------------------------------------------------------------------------
module ir_nec_transmitter #(
    parameter int unsigned T_LEAD_MARK  = 450000,
    parameter int unsigned T_LEAD_SPACE = 225000,
    parameter int unsigned T_BIT_MARK   = 28125,
    parameter int unsigned T_SPACE_0    = 28125,
    parameter int unsigned T_SPACE_1    = 84375,
    parameter int unsigned T_GAP        = 1500000,
    parameter logic [15:0] CUSTOM_CODE  = 16'h6B86
`ifdef IR_CARRIER_EN
    , parameter int unsigned CARRIER_HALF = 658
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] key_code,
    output logic       busy,
    output logic       done,
    output logic       IRDA_TXD
);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
    } state_t;

    state_t      state;
    logic [20:0] cnt;        // cycles elapsed in the current segment
    logic [20:0] seg_last;   // terminal count of the current segment
    logic        seg_end;
    logic [4:0]  bit_cnt;
    logic [31:0] shift_reg;

    // Terminal count depends on the segment; a data space's length is chosen
    // by the bit currently at the bottom of the shift register.
    always_comb begin
        seg_last = '0;
        case (state)
            LEAD_MARK:  seg_last = 21'(T_LEAD_MARK - 1);
            LEAD_SPACE: seg_last = 21'(T_LEAD_SPACE - 1);
            BIT_MARK:   seg_last = 21'(T_BIT_MARK - 1);
            BIT_SPACE:  seg_last = shift_reg[0] ? 21'(T_SPACE_1 - 1) : 21'(T_SPACE_0 - 1);
            STOP_MARK:  seg_last = 21'(T_BIT_MARK - 1);
            GAP:        seg_last = 21'(T_GAP - 1);
            default:    seg_last = '0;
        endcase
    end

    assign seg_end = (cnt == seg_last);

`ifdef IR_CARRIER_EN
    localparam logic [15:0] CAR_LAST = 16'(CARRIER_HALF - 1);
    logic [15:0] car_cnt;
    logic        in_mark;
    assign in_mark = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            IRDA_TXD  <= 1'b1;
`ifdef IR_CARRIER_EN
            car_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            cnt  <= (state == IDLE || seg_end) ? '0 : cnt + 21'd1;

`ifdef IR_CARRIER_EN
            // Carrier phase restarts with every mark; every segment change
            // below sets IRDA_TXD explicitly, overriding this toggle.
            if (!in_mark || seg_end) begin
                car_cnt <= '0;
            end else if (car_cnt == CAR_LAST) begin
                car_cnt  <= '0;
                IRDA_TXD <= ~IRDA_TXD;
            end else begin
                car_cnt <= car_cnt + 16'd1;
            end
`endif

            case (state)
                IDLE: begin
                    IRDA_TXD <= 1'b1;
                    if (start) begin
                        state     <= LEAD_MARK;
                        busy      <= 1'b1;
                        IRDA_TXD  <= 1'b0;
                        shift_reg <= {~key_code, key_code, CUSTOM_CODE};
                    end
                end
                LEAD_MARK: if (seg_end) begin
                    state    <= LEAD_SPACE;
                    IRDA_TXD <= 1'b1;
                end
                LEAD_SPACE: if (seg_end) begin
                    state    <= BIT_MARK;
                    bit_cnt  <= '0;
                    IRDA_TXD <= 1'b0;
                end
                BIT_MARK: if (seg_end) begin
                    state    <= BIT_SPACE;
                    IRDA_TXD <= 1'b1;
                end
                BIT_SPACE: if (seg_end) begin
                    shift_reg <= {1'b0, shift_reg[31:1]};
                    IRDA_TXD  <= 1'b0;
                    if (bit_cnt == 5'd31) begin
                        state <= STOP_MARK;
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        state   <= BIT_MARK;
                    end
                end
                STOP_MARK: if (seg_end) begin
                    state    <= GAP;
                    IRDA_TXD <= 1'b1;
                end
                GAP: if (seg_end) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    IRDA_TXD <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// ---------------------------------------------------------------------------
// tb_ir_nec_transmitter
//   Scoreboard bench for ir_nec_transmitter with shortened segment timings.
//   The stimulus pushes the expected segment list and frame record (done
//   cycle, data word) for each accepted frame; a monitor measures every
//   IRDA_TXD run, decodes the data spaces and pops/compares.
// ---------------------------------------------------------------------------
module tb_ir_nec_transmitter;

    localparam int TLM = 16;
    localparam int TLS = 8;
    localparam int TBM = 2;
    localparam int TS0 = 2;
    localparam int TS1 = 6;
    localparam int TG  = 20;
    localparam int CH  = 3;
    // 16 + 8 lead, 32 marks * 2, 16 zero-spaces * 2 + 16 one-spaces * 6,
    // stop mark 2, gap 20
    localparam int FRAME_DONE = 238;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       busy, done, IRDA_TXD;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct { logic lvl; int len; } seg_t;
    typedef struct { int done_cyc; logic [31:0] word; } frm_t;
    seg_t seg_q[$];
    frm_t frm_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ir_nec_transmitter #(
        .T_LEAD_MARK (TLM),
        .T_LEAD_SPACE(TLS),
        .T_BIT_MARK  (TBM),
        .T_SPACE_0   (TS0),
        .T_SPACE_1   (TS1),
        .T_GAP       (TG),
        .CUSTOM_CODE (16'h6B86)
`ifdef IR_CARRIER_EN
        , .CARRIER_HALF(CH)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key_code(key_code),
        .busy    (busy),
        .done    (done),
        .IRDA_TXD(IRDA_TXD)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] word, input int s);
        seg_q.push_back('{1'b0, TLM});
        seg_q.push_back('{1'b1, TLS});
        for (int i = 0; i < 32; i++) begin
            seg_q.push_back('{1'b0, TBM});
            seg_q.push_back('{1'b1, word[i] ? TS1 : TS0});
        end
        seg_q.push_back('{1'b0, TBM});
        seg_q.push_back('{1'b1, TG});
        frm_q.push_back('{s + FRAME_DONE, word});
    endtask

    // now=1: raise start at the current negedge (used right after done).
    // Returns s = cycle number of the accepting edge.
    task automatic start_frame(input logic [7:0] key, input logic [31:0] word,
                               input bit now, output int s);
        if (!now) @(negedge clk);
        key_code = key;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        key_code = ~key;   // must not affect the frame in flight
        s        = cyc;
`ifndef IR_CARRIER_EN
        push_frame(word, s);
`endif
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL done_timeout: no done within %0d cycles", budget);
    endtask

    task automatic reset_now(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, " txd"},  IRDA_TXD, 1'b1);
        chk({tag, " busy"}, busy,     1'b0);
        chk({tag, " done"}, done,     1'b0);
        seg_q.delete();
        frm_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifndef IR_CARRIER_EN
    initial begin : monitor
        logic        prev;
        bit          in_frame, busy_drop, chk_low;
        int          last_chg, seg_idx, run;
        logic [31:0] dec;
        seg_t        s;
        frm_t        f;
        prev = 1'b1; in_frame = 0; busy_drop = 0; chk_low = 0;
        last_chg = 0; seg_idx = 0; dec = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1; in_frame = 0; chk_low = 0;
                continue;
            end
            if (chk_low) begin
                chk("done_width", done, 1'b0);
                chk_low = 0;
            end
            if (IRDA_TXD !== prev) begin
                if (!in_frame) begin
                    in_frame = 1; seg_idx = 0; dec = '0; busy_drop = 0;
                end else begin
                    run = cyc - last_chg;
                    if (seg_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL extra_segment: level %0b len %0d, expected none", prev, run);
                    end else begin
                        s = seg_q.pop_front();
                        chk($sformatf("seg%0d_level", seg_idx), 32'(prev), 32'(s.lvl));
                        chk($sformatf("seg%0d_len", seg_idx), run, s.len);
                    end
                    if (seg_idx >= 3 && seg_idx <= 65 && seg_idx % 2 == 1)
                        dec[(seg_idx - 3) / 2] = (run > (TS0 + TS1) / 2);
                    seg_idx++;
                end
                last_chg = cyc;
                prev     = IRDA_TXD;
            end
            if (in_frame && !busy && !done) busy_drop = 1;
            if (done) begin
                chk_low = 1;
                if (frm_q.size() == 0 || seg_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: done at cycle %0d, expected none", cyc);
                end else begin
                    f   = frm_q.pop_front();
                    s   = seg_q.pop_front();
                    run = cyc - last_chg;
                    chk("gap_len",    run,       s.len);
                    chk("done_cycle", cyc,       f.done_cyc);
                    chk("data_word",  dec,       f.word);
                    chk("busy_held",  busy_drop, 1'b0);
                    chk("busy_clear", busy,      1'b0);
                end
                in_frame = 0;
            end
        end
    end
`endif

    initial begin : stim
        int s;
        #2 rst = 1'b1;
        #1;
        chk("reset txd",  IRDA_TXD, 1'b1);
        chk("reset busy", busy,     1'b0);
        chk("reset done", done,     1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

`ifdef IR_CARRIER_EN
        // Lead mark: half-periods of CH cycles, last one truncated; space high.
        start_frame(8'h00, 32'hFF006B86, 0, s);
        for (int k = 0; k < TLM + TLS; k++) begin
            chk($sformatf("carrier_k%0d", k), 32'(IRDA_TXD),
                (k < TLM) ? 32'((k / CH) % 2) : 32'd1);
            @(negedge clk);
        end
        wait_done(400);
        chk("carrier done_cycle", cyc, s + FRAME_DONE);
        chk("carrier idle txd", IRDA_TXD, 1'b1);
`else
        // Basic frame; key_code scrambled after acceptance.
        start_frame(8'h45, 32'hBA456B86, 0, s);
        wait_done(400);

        // Second key, distinct bit pattern.
        start_frame(8'h3C, 32'hC33C6B86, 0, s);
        wait_done(400);

        // Start pulses while busy: at s+5, and sampled on the done edge.
        start_frame(8'h45, 32'hBA456B86, 0, s);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + FRAME_DONE - 1) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4 done_on_edge", done, 1'b1);
        repeat (30) @(negedge clk);
        chk("t4 no_refire busy", busy, 1'b0);
        chk("t4 no_refire txd",  IRDA_TXD, 1'b1);
        chk("t4 queue_empty",    frm_q.size(), 0);

        // Asynchronous reset in lead mark, between clock edges.
        start_frame(8'h55, 32'hAA556B86, 0, s);
        repeat (10) @(negedge clk);
        reset_now("abort_mark");

        // Reset in lead space, then a clean full frame.
        start_frame(8'hAA, 32'h55AA6B86, 0, s);
        repeat (20) @(negedge clk);
        reset_now("abort_space");
        start_frame(8'h01, 32'hFE016B86, 0, s);
        wait_done(400);

        // Start raised the cycle after done: accepted immediately.
        start_frame(8'h00, 32'hFF006B86, 1, s);
        wait_done(400);
        repeat (5) @(negedge clk);
        chk("final busy", busy, 1'b0);
        chk("final txd",  IRDA_TXD, 1'b1);
        chk("final frames_left", frm_q.size(), 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
